// File: rtl/sbox_lane_scheduler.sv
// rtl/sbox_lane_scheduler.sv - shares one 32-bit S-box lane between state SubBytes and key SubWord
module sbox_lane_scheduler #(
    parameter int KEY_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_res_valid,
    output logic [127:0] st_res,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_word,
    output logic         key_res_valid,
    output logic [31:0]  key_res,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out
);

    typedef enum logic {IDLE, BUSY} fsm_t;

    fsm_t        state;
    fsm_t        state_next;
    logic [1:0]  cnt;
    logic        last_key;
    logic [31:0] word_q [4];
    logic        st_cand;
    logic        key_cand;
    logic        grant_key;
    logic        grant_st;
    logic        accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration: a lone candidate always wins; on conflict either key priority or
    // the requester that did not hold the lane last.
    always_comb begin
        st_cand    = (state == BUSY) && !rst;
        key_cand   = key_valid && !rst;
        grant_key  = key_cand && (!st_cand || (KEY_PRIO != 0) || !last_key);
        grant_st   = st_cand && !grant_key;
        st_ready   = (state == IDLE) && !rst;
        accept     = st_valid && st_ready;
        key_ready  = grant_key;
        sb_in      = 32'd0;
        state_next = state;
        if (grant_key) begin
            sb_in = key_word;
        end else if (grant_st) begin
            sb_in = word_q[cnt];
        end
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (grant_st && (cnt == 2'd3)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 2'd0;
            last_key      <= 1'b1;
            word_q[0]     <= 32'd0;
            word_q[1]     <= 32'd0;
            word_q[2]     <= 32'd0;
            word_q[3]     <= 32'd0;
            key_res       <= 32'd0;
            key_res_valid <= 1'b0;
            st_res_valid  <= 1'b0;
        end else begin
            st_res_valid  <= grant_st && (cnt == 2'd3);
            key_res_valid <= grant_key;
            if (grant_key) begin
                key_res <= sb_out;
            end
            if (grant_key || grant_st) begin
                last_key <= grant_key;
            end
            if (accept) begin
                word_q[0] <= st_data[127:96];
                word_q[1] <= st_data[95:64];
                word_q[2] <= st_data[63:32];
                word_q[3] <= st_data[31:0];
                cnt       <= 2'd0;
            end else if (grant_st) begin
                word_q[cnt] <= sb_out;
                cnt         <= cnt + 2'd1;
            end
        end
    end

    // Mid-job the buffer is partially substituted; consumers only sample on st_res_valid.
    assign st_res = {word_q[0], word_q[1], word_q[2], word_q[3]};

endmodule
